dmem_resp: RTL
==============

# dmem_resp

Data-memory responder on the execute-stage memory access interface (`acs_*`). It services byte, half, word and double requests of right-aligned data at any byte address. It splits requests that straddle an XLEN-word boundary into two synchronous-RAM beats. It signals completion with a one-cycle `acs_ready` pulse, which the core uses as its stall release. It sits between the execution unit and an internal single-port synchronous RAM.

## Interface
- `XLEN`, 64, data/address width; word = XLEN/8 bytes, offset bits OB = log2(XLEN/8)
- `DEPTH`, 4096, RAM words
- `BASE`, 64'h8000_0000, byte address of RAM word 0
- `clk`  in  1  clock
- `rst_n`  in  1  reset; synchronous, active-low
- `acs_en`  in  1  request valid; held stable with all `acs_*` inputs until `acs_ready`
- `acs_wr`  in  1  1 = write, 0 = read
- `acs_bytes`  in  XLEN/8  size mask, right-aligned; legal values 8'h01, 8'h03, 8'h0f, 8'hff
- `acs_addr`  in  XLEN  byte address
- `acs_wdata`  in  XLEN  write data, right-aligned
- `acs_rdata`  out  XLEN  read data, right-aligned, zero above size; valid while `acs_ready`=1
- `acs_ready`  out  1  one-cycle completion pulse
- `acs_err`  out  1  valid with `acs_ready`; 1 = request rejected

## Operation
- Decode at acceptance:
  - off = acs_addr[OB-1:0]
  - idx = (acs_addr - BASE) >> OB
  - lane = acs_bytes << off, 2·XLEN/8 bits wide
  - split = upper half of lane nonzero
- Error when any of:
  - acs_addr < BASE
  - idx ≥ DEPTH
  - split and idx+1 ≥ DEPTH
  - acs_bytes not a legal value
- On error: no RAM access, go to RESP with `acs_err`=1 and `acs_rdata`=0.
- States: IDLE, WR_HI, RD_LO, RD_HI, RESP.
- IDLE, acs_en=1 at edge:
  - error → RESP
  - write → write low lanes of (acs_wdata << 8·off) to word idx with byte enables lane[low]; then WR_HI if split, else RESP
  - read → issue RAM read of idx; go to RD_LO
- WR_HI: write lane[high] bytes to idx+1 → RESP.
- RD_LO: latch RAM output as lo.
  - split → issue read of idx+1, go to RD_HI
  - not split → load `acs_rdata` = ({0,lo} >> 8·off) masked by acs_bytes; go to RESP
- RD_HI: latch hi; load `acs_rdata` = ({hi,lo} >> 8·off) masked → RESP.
- RESP: `acs_ready`=1 for exactly this cycle; no acceptance in this cycle; → IDLE.
- acs_en=0 in non-IDLE states is ignored; the transaction completes.
- Little-endian byte order throughout.
- Sign extension is not done here; the requester applies it.
- RAM contents are not initialised or cleared by reset.

## Timing
- Reset (rst_n=0 at edge): state IDLE, `acs_ready`=0, `acs_err`=0, `acs_rdata`=0. Any in-flight transaction is abandoned.
  - A split write hit in WR_HI keeps its low half written; the high half is not written.
- Latency, counted from the accept edge (cycle 0) to the cycle `acs_ready`=1:
  - error: 1
  - aligned write: 1
  - split write: 2
  - aligned read: 2
  - split read: 3
- `acs_rdata` and `acs_err` are registered.
  - Both hold their values after RESP until the next load.
  - `acs_err` clears to 0 when the next request is accepted.
- Throughput: one request per (latency+1) cycles. A new request is sampled in the first IDLE cycle after RESP.
- Write then read of the same bytes on back-to-back requests returns the new data (no bypass needed, since the write completes before the read is issued).

## Test plan
- sd 64'h1122334455667788, bytes 8'hff @ 0x8000_0010 → ready at cycle 1, err=0. Then ld @ 0x8000_0010 → ready at cycle 2, rdata 64'h1122334455667788.
- sh 16'hBEEF, bytes 8'h03 @ 0x8000_0013 → ready at cycle 1. Then lw (8'h0f) @ 0x8000_0010 → rdata 64'h0000_0000_EF66_7788.
- Word 0x8000_0018 and word 0x8000_0020 pre-zeroed. sw 32'hAABBCCDD @ 0x8000_001E → ready at cycle 2. Then:
  - ld @ 0x8000_0018 → 64'hCCDD_0000_0000_0000
  - ld @ 0x8000_0020 → 64'h0000_0000_0000_AABB
  - lw @ 0x8000_001E → ready at cycle 3, rdata 64'h0000_0000_AABB_CCDD
- Each of the following → ready at cycle 1, err=1, rdata 0, RAM unchanged:
  - lw @ 0x7FFF_FFFC
  - bytes 8'h07 @ 0x8000_0000
  - sd @ 0x8000_7FFC (split past word 4095)
- Split sw 32'hAABBCCDD @ 0x8000_0046; rst_n=0 in the WR_HI cycle → next cycle ready=0, err=0, rdata=0, state IDLE. Subsequent ld @ 0x8000_0040 shows bytes 6–7 = DD,CC; word 0x8000_0048 is unchanged.
- sb 8'h5A @ 0x8000_0101 with acs_en held continuously, then lbu @ 0x8000_0101 → exactly one ready pulse per request, sampled on separate IDLE cycles; lbu rdata 64'h5A.

Source files
------------

// File: rtl/dmem_resp.sv
// Data-memory responder: services byte/half/word/double accesses at any byte
// address, splitting boundary-straddling requests into two RAM beats.
module dmem_resp #(
    parameter int              XLEN  = 64,
    parameter int              DEPTH = 4096,
    parameter logic [XLEN-1:0] BASE  = XLEN'(64'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acs_en,
    input  logic              acs_wr,
    input  logic [XLEN/8-1:0] acs_bytes,
    input  logic [XLEN-1:0]   acs_addr,
    input  logic [XLEN-1:0]   acs_wdata,
    output logic [XLEN-1:0]   acs_rdata,
    output logic              acs_ready,
    output logic              acs_err
);

    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WR_HI, S_RD_LO, S_RD_HI, S_RESP} state_t;

    function automatic logic legal_size(input logic [NB-1:0] b);
        legal_size = 1'b0;
        for (int k = 0; (1 << k) <= NB; k++) begin
            if (b == NB'((1 << (1 << k)) - 1)) legal_size = 1'b1;
        end
    endfunction

    function automatic logic [XLEN-1:0] byte_mask(input logic [NB-1:0] b);
        for (int i = 0; i < NB; i++) byte_mask[8*i +: 8] = {8{b[i]}};
    endfunction

    state_t             r_state;
    state_t             w_next;

    logic [XLEN-1:0]    r_mem [DEPTH];
    logic [XLEN-1:0]    r_ram_q;

    logic [IW-1:0]      r_idx;
    logic [OB-1:0]      r_off;
    logic [NB-1:0]      r_bytes;
    logic               r_split;
    logic [NB-1:0]      r_be_hi;
    logic [XLEN-1:0]    r_wd_hi;
    logic [XLEN-1:0]    r_lo;
    logic [XLEN-1:0]    r_rdata;
    logic               r_err;

    logic [OB-1:0]      w_off;
    logic [XLEN-1:0]    w_idx;
    logic [2*NB-1:0]    w_lane;
    logic [2*XLEN-1:0]  w_wsh;
    logic               w_split;
    logic               w_err;
    logic               w_accept;
    logic [2*XLEN-1:0]  w_rd_cat;
    logic [XLEN-1:0]    w_rd;

    logic               w_ram_we;
    logic               w_ram_re;
    logic [IW-1:0]      w_ram_addr;
    logic [NB-1:0]      w_ram_be;
    logic [XLEN-1:0]    w_ram_wdata;

    // Request decode, evaluated against the live inputs in IDLE
    assign w_off    = acs_addr[OB-1:0];
    assign w_idx    = (acs_addr - BASE) >> OB;
    assign w_lane   = {{NB{1'b0}}, acs_bytes} << w_off;
    assign w_wsh    = {{XLEN{1'b0}}, acs_wdata} << {w_off, 3'b000};
    assign w_split  = |w_lane[2*NB-1:NB];
    assign w_err    = (acs_addr < BASE)
                    | (w_idx >= XLEN'(DEPTH))
                    | (w_split & ((w_idx + XLEN'(1)) >= XLEN'(DEPTH)))
                    | ~legal_size(acs_bytes);
    assign w_accept = (r_state == S_IDLE) & acs_en;

    // Non-split reads see zeros above the low word so the shift cannot pull in stale data
    assign w_rd_cat = (r_state == S_RD_HI) ? {r_ram_q, r_lo} : {{XLEN{1'b0}}, r_ram_q};
    assign w_rd     = XLEN'(w_rd_cat >> {r_off, 3'b000}) & byte_mask(r_bytes);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (acs_en) begin
                    if (w_err)       w_next = S_RESP;
                    else if (acs_wr) w_next = w_split ? S_WR_HI : S_RESP;
                    else             w_next = S_RD_LO;
                end
            end
            S_WR_HI: w_next = S_RESP;
            S_RD_LO: w_next = r_split ? S_RD_HI : S_RESP;
            S_RD_HI: w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_addr  = w_idx[IW-1:0];
        w_ram_be    = '0;
        w_ram_wdata = w_wsh[XLEN-1:0];
        case (r_state)
            S_IDLE: begin
                if (acs_en && !w_err) begin
                    if (acs_wr) begin
                        w_ram_we = 1'b1;
                        w_ram_be = w_lane[NB-1:0];
                    end else begin
                        w_ram_re = 1'b1;
                    end
                end
            end
            S_WR_HI: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = r_idx + IW'(1);
                w_ram_be    = r_be_hi;
                w_ram_wdata = r_wd_hi;
            end
            S_RD_LO: begin
                if (r_split) begin
                    w_ram_re   = 1'b1;
                    w_ram_addr = r_idx + IW'(1);
                end
            end
            default: ;
        endcase
        // An abandoned transaction must not commit its pending beat
        if (!rst_n) w_ram_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < NB; i++) begin
                if (w_ram_be[i]) r_mem[w_ram_addr][8*i +: 8] <= w_ram_wdata[8*i +: 8];
            end
        end
        if (w_ram_re) r_ram_q <= r_mem[w_ram_addr];
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx   <= w_idx[IW-1:0];
            r_off   <= w_off;
            r_bytes <= acs_bytes;
            r_split <= w_split;
            r_be_hi <= w_lane[2*NB-1:NB];
            r_wd_hi <= w_wsh[2*XLEN-1:XLEN];
        end
        if (r_state == S_RD_LO) r_lo <= r_ram_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_err <= w_err;
                if (w_err) r_rdata <= '0;
            end
            if ((r_state == S_RD_LO && !r_split) || r_state == S_RD_HI) r_rdata <= w_rd;
        end
    end

    assign acs_ready = (r_state == S_RESP);
    assign acs_rdata = r_rdata;
    assign acs_err   = r_err;

endmodule
